// File: rtl/gamepad_pmod_multi_rx_pkg.sv
// gamepad_pmod_pkg: shared constants and pad-word helpers for the gamepad pmod receiver
package gamepad_pmod_pkg;
   localparam int BITS_PER_PAD = 12;
   typedef logic [BITS_PER_PAD-1:0] pad_word_t;
   localparam pad_word_t EMPTY_PAD = 12'hFFF;
   localparam int BTN_B      = 11;
   localparam int BTN_Y      = 10;
   localparam int BTN_SELECT = 9;
   localparam int BTN_START  = 8;
   localparam int BTN_UP     = 7;
   localparam int BTN_DOWN   = 6;
   localparam int BTN_LEFT   = 5;
   localparam int BTN_RIGHT  = 4;
   localparam int BTN_A      = 3;
   localparam int BTN_X      = 2;
   localparam int BTN_L      = 1;
   localparam int BTN_R      = 0;
   // An all-ones word means nothing is plugged in, which reads as no buttons held
   function automatic pad_word_t pad_state(input pad_word_t raw);
      return (raw == EMPTY_PAD) ? '0 : raw;
   endfunction
endpackage

// File: rtl/gamepad_pmod_multi_rx_if.sv
// gamepad_pmod_multi_rx_if: pmod pins towards the receiver, decoded pad state back out
interface gamepad_pmod_multi_rx_if #(parameter int NUM_PADS = 2);
   import gamepad_pmod_pkg::*;
   logic                           pmod_data;
   logic                           pmod_clk;
   logic                           pmod_latch;
   logic [NUM_PADS*BITS_PER_PAD-1:0] buttons;
   logic [NUM_PADS*BITS_PER_PAD-1:0] pressed_evt;
   logic [NUM_PADS*BITS_PER_PAD-1:0] released_evt;
   logic [NUM_PADS-1:0]            is_present;
   logic                           frame_valid;
   logic                           frame_err;
   logic                           link_active;
   modport master (output pmod_data, pmod_clk, pmod_latch,
                   input  buttons, pressed_evt, released_evt, is_present, frame_valid, frame_err, link_active);
   modport slave  (input  pmod_data, pmod_clk, pmod_latch,
                   output buttons, pressed_evt, released_evt, is_present, frame_valid, frame_err, link_active);
endinterface

// File: rtl/gamepad_pmod_multi_rx_pad_decode.sv
// gamepad_pmod_pad_decode: registers one pad's buttons/presence and its press/release pulses
module gamepad_pmod_pad_decode
   import gamepad_pmod_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      upd,
   input  pad_word_t raw,
   output pad_word_t buttons,
   output pad_word_t pressed_evt,
   output pad_word_t released_evt,
   output logic      is_present
);
   pad_word_t state;
   assign state = pad_state(raw);
   // Load new state on an update strobe; events are the bitwise difference and last one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buttons      <= '0;
         pressed_evt  <= '0;
         released_evt <= '0;
         is_present   <= 1'b0;
      end else begin
         pressed_evt  <= upd ? state & ~buttons : '0;
         released_evt <= upd ? ~state & buttons : '0;
         if (upd) begin
            buttons    <= state;
            is_present <= raw != EMPTY_PAD;
         end
      end
   end
endmodule

// File: rtl/gamepad_pmod_multi_rx.sv
// gamepad_pmod_multi_rx: multi-pad gamepad pmod receiver with length check, events and link timeout
module gamepad_pmod_multi_rx
   import gamepad_pmod_pkg::*;
#(
   parameter int NUM_PADS       = 2,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input logic                    clk,
   input logic                    reset,
   gamepad_pmod_multi_rx_if.slave bus
);
   localparam int MAX = NUM_PADS * BITS_PER_PAD;
   localparam int CW  = $clog2(MAX + 2);
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_SAT = CW'(MAX + 1);

   logic [SYNC_STAGES-1:0] sync_d, sync_c, sync_l;
   logic                   prev_c, prev_l;
   logic                   clk_rise, latch_rise, good;
   logic [MAX-1:0]         shift_reg, data_reg, next_data;
   logic [CW-1:0]          bit_cnt;
   logic [TW-1:0]          to_cnt;
   logic                   link, commit_stb, err_stb, drop_stb;
   logic                   frame_valid, frame_err, link_active;
   logic [MAX-1:0]         buttons, pressed, released;
   logic [NUM_PADS-1:0]    present;

   // Bring the three asynchronous pmod pins into the clk domain and remember the last level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_d <= '0;
         sync_c <= '0;
         sync_l <= '0;
         prev_c <= 1'b0;
         prev_l <= 1'b0;
      end else begin
         sync_d <= {sync_d[SYNC_STAGES-2:0], bus.pmod_data};
         sync_c <= {sync_c[SYNC_STAGES-2:0], bus.pmod_clk};
         sync_l <= {sync_l[SYNC_STAGES-2:0], bus.pmod_latch};
         prev_c <= sync_c[SYNC_STAGES-1];
         prev_l <= sync_l[SYNC_STAGES-1];
      end
   end

   assign clk_rise   = sync_c[SYNC_STAGES-1] & ~prev_c;
   assign latch_rise = sync_l[SYNC_STAGES-1] & ~prev_l;

   // Length is good only on a whole number of pads; pads beyond the received count read as absent
   always_comb begin
      good      = 1'b0;
      next_data = '1;
      for (int p = 0; p < NUM_PADS; p++) begin
         if (bit_cnt == CW'((p + 1) * BITS_PER_PAD)) good = 1'b1;
         if (bit_cnt >= CW'((p + 1) * BITS_PER_PAD)) next_data[p*BITS_PER_PAD +: BITS_PER_PAD] = shift_reg[p*BITS_PER_PAD +: BITS_PER_PAD];
      end
   end

   // Shift, count, commit on latch and drop the link when no good frame arrives in time
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg  <= '1;
         data_reg   <= '1;
         bit_cnt    <= '0;
         to_cnt     <= '0;
         link       <= 1'b0;
         commit_stb <= 1'b0;
         err_stb    <= 1'b0;
         drop_stb   <= 1'b0;
      end else begin
         commit_stb <= latch_rise & good;
         err_stb    <= latch_rise & ~good;
         drop_stb   <= 1'b0;
         if (clk_rise) shift_reg <= {shift_reg[MAX-2:0], sync_d[SYNC_STAGES-1]};
         if (latch_rise) bit_cnt <= clk_rise ? CW'(1) : '0;
         else if (clk_rise && bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
         if (latch_rise && good) begin
            data_reg <= next_data;
            to_cnt   <= '0;
            link     <= 1'b1;
         end else if (link && to_cnt == TO_LAST) begin
            data_reg <= '1;
            link     <= 1'b0;
            drop_stb <= 1'b1;
         end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   // Status pulses line up with the decoder outputs, one stage after the commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         link_active <= 1'b0;
      end else begin
         frame_valid <= commit_stb;
         frame_err   <= err_stb;
         link_active <= link;
      end
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      gamepad_pmod_pad_decode u_pad (
         .clk          (clk),
         .reset        (reset),
         .upd          (commit_stb | drop_stb),
         .raw          (data_reg[p*BITS_PER_PAD +: BITS_PER_PAD]),
         .buttons      (buttons[p*BITS_PER_PAD +: BITS_PER_PAD]),
         .pressed_evt  (pressed[p*BITS_PER_PAD +: BITS_PER_PAD]),
         .released_evt (released[p*BITS_PER_PAD +: BITS_PER_PAD]),
         .is_present   (present[p])
      );
   end

   assign bus.buttons      = buttons;
   assign bus.pressed_evt  = pressed;
   assign bus.released_evt = released;
   assign bus.is_present   = present;
   assign bus.frame_valid  = frame_valid;
   assign bus.frame_err    = frame_err;
   assign bus.link_active  = link_active;
endmodule

// File: tb/tb_gamepad_pmod_multi_rx.sv
// tb_gamepad_pmod_multi_rx: randomized scoreboard bench for the two-pad receiver
module tb_gamepad_pmod_multi_rx;
   typedef struct packed {
      logic        fv;
      logic        fe;
      logic [23:0] btn;
      logic [23:0] prs;
      logic [23:0] rel;
      logic [1:0]  pres;
      logic        link;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   logic [23:0] m_btn = '0;
   logic [1:0]  m_pres = '0;
   logic        m_link = 1'b0;
   time         last_good = 0;
   logic        plink = 1'b0;

   always #5 clk = ~clk;

   gamepad_pmod_multi_rx_if #(.NUM_PADS(2)) bus ();

   gamepad_pmod_multi_rx #(.NUM_PADS(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(4096)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset) begin
         plink = 1'b0;
      end else begin
         if (bus.frame_valid || bus.frame_err || (plink && !bus.link_active)) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: fv=%0b fe=%0b link=%0b with nothing expected", bus.frame_valid, bus.frame_err, bus.link_active);
            end else begin
               e = q.pop_front();
               check("frame_valid", 32'(bus.frame_valid), 32'(e.fv));
               check("frame_err", 32'(bus.frame_err), 32'(e.fe));
               check("buttons", 32'(bus.buttons), 32'(e.btn));
               check("pressed_evt", 32'(bus.pressed_evt), 32'(e.prs));
               check("released_evt", 32'(bus.released_evt), 32'(e.rel));
               check("is_present", 32'(bus.is_present), 32'(e.pres));
               check("link_active", 32'(bus.link_active), 32'(e.link));
            end
         end else begin
            check("idle_events", 32'(bus.pressed_evt | bus.released_evt), 32'h0);
         end
         plink = bus.link_active;
      end
   end

   // Reference model: frame rules applied to whole pad words
   task automatic expect_frame(input int n, input logic [31:0] v);
      exp_t        e;
      logic [11:0] raw;
      logic [23:0] nb;
      logic [1:0]  np;
      if (n > 0 && n <= 24 && n % 12 == 0) begin
         nb = '0;
         np = '0;
         for (int p = 0; p < 2; p++) begin
            raw = (p < n / 12) ? v[p*12 +: 12] : 12'hFFF;
            np[p] = raw != 12'hFFF;
            nb[p*12 +: 12] = np[p] ? raw : 12'h000;
         end
         e = '{fv: 1'b1, fe: 1'b0, btn: nb, prs: nb & ~m_btn, rel: ~nb & m_btn, pres: np, link: 1'b1};
         m_btn = nb;
         m_pres = np;
         m_link = 1'b1;
         last_good = $time;
      end else begin
         e = '{fv: 1'b0, fe: 1'b1, btn: m_btn, prs: '0, rel: '0, pres: m_pres, link: m_link};
      end
      q.push_back(e);
   endtask

   task automatic send_bits(input int n, input logic [31:0] v);
      for (int i = n - 1; i >= 0; i--) begin
         bus.pmod_data = v[i];
         wait_cyc(3);
         bus.pmod_clk = 1'b1;
         wait_cyc(3);
         bus.pmod_clk = 1'b0;
         wait_cyc(1);
      end
   endtask

   task automatic latch();
      bus.pmod_latch = 1'b1;
      wait_cyc(4);
      bus.pmod_latch = 1'b0;
      wait_cyc(4);
   endtask

   task automatic frame(input int n, input logic [31:0] v);
      expect_frame(n, v);
      send_bits(n, v);
      latch();
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() != 0; i++) wait_cyc(1);
      check("drain_pending", 32'(q.size()), 32'h0);
      q.delete();
   endtask

   initial begin
      int          lat;
      int          n;
      logic [31:0] v;
      logic [23:0] a;
      logic [23:0] b;
      exp_t        e;
      bus.pmod_data = 1'b0;
      bus.pmod_clk = 1'b0;
      bus.pmod_latch = 1'b0;
      wait_cyc(3);
      check("rst_buttons", 32'(bus.buttons), 32'h0);
      check("rst_events", 32'(bus.pressed_evt | bus.released_evt), 32'h0);
      check("rst_present", 32'(bus.is_present), 32'h0);
      check("rst_flags", {29'h0, bus.frame_valid, bus.frame_err, bus.link_active}, 32'h0);
      reset = 1'b0;
      wait_cyc(2);

      // Reset in the middle of a frame discards it
      frame(24, {8'h0, 12'h0A5, 12'h3C0});
      drain();
      send_bits(7, 32'h55);
      #2 reset = 1'b1;
      #1;
      check("midrst_buttons", 32'(bus.buttons), 32'h0);
      check("midrst_present", 32'(bus.is_present), 32'h0);
      check("midrst_link", 32'(bus.link_active), 32'h0);
      m_btn = '0;
      m_pres = '0;
      m_link = 1'b0;
      wait_cyc(2);
      reset = 1'b0;
      wait_cyc(2);
      frame(24, {8'h0, 12'h5A5, 12'h00F});
      drain();

      // Pad 1 absent, with latency measured from the latch
      expect_frame(24, {8'h0, 12'hFFF, 12'h800});
      send_bits(24, {8'h0, 12'hFFF, 12'h800});
      bus.pmod_latch = 1'b1;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         wait_cyc(1);
         if (bus.frame_valid && lat == 0) lat = i;
      end
      bus.pmod_latch = 1'b0;
      wait_cyc(2);
      check("latch_latency", 32'(lat), 32'd4);
      drain();

      // Short, bad and empty frames
      frame(12, 32'h0C0);
      frame(13, $urandom);
      frame(25, $urandom);
      frame(0, 32'h0);
      drain();

      // Release event, then latch and clk rising together
      frame(24, {8'h0, 12'h000, 12'h800});
      frame(24, 32'h0);
      a = 24'h3A5_C01;
      b = 24'h812_47E;
      expect_frame(24, {8'h0, a});
      send_bits(24, {8'h0, a});
      bus.pmod_data = b[23];
      wait_cyc(3);
      bus.pmod_latch = 1'b1;
      bus.pmod_clk = 1'b1;
      wait_cyc(3);
      bus.pmod_clk = 1'b0;
      wait_cyc(1);
      bus.pmod_latch = 1'b0;
      wait_cyc(3);
      expect_frame(24, {8'h0, b});
      send_bits(23, {9'h0, b[22:0]});
      latch();
      drain();

      // Randomized frames of mixed length
      for (int it = 0; it < 40; it++) begin
         n = $urandom_range(0, 9);
         n = (n < 4) ? 24 : (n < 6) ? 12 : int'($urandom_range(0, 30));
         if (m_link && ($time - last_good) > 25000) n = 24;
         v = $urandom;
         if ($urandom_range(0, 4) == 0) v[11:0] = 12'hFFF;
         if ($urandom_range(0, 4) == 0) v[23:12] = 12'hFFF;
         frame(n, v);
         wait_cyc(int'($urandom_range(0, 5)));
      end
      drain();

      // Link timeout releases the held buttons exactly once
      frame(24, {8'h0, 12'h123, 12'h800});
      drain();
      e = '{fv: 1'b0, fe: 1'b0, btn: '0, prs: '0, rel: m_btn, pres: '0, link: 1'b0};
      q.push_back(e);
      m_btn = '0;
      m_pres = '0;
      m_link = 1'b0;
      for (int i = 0; i < 5000 && q.size() != 0; i++) wait_cyc(1);
      check("timeout_drop_pending", 32'(q.size()), 32'h0);
      q.delete();
      wait_cyc(4500);
      check("lost_link", 32'(bus.link_active), 32'h0);
      check("lost_present", 32'(bus.is_present), 32'h0);
      check("lost_buttons", 32'(bus.buttons), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
